// File: rtl/line_matrix_pkg.sv
// rtl/line_matrix_pkg.sv - shared widths, source codes and FSM states for line_matrix and its loader
package line_matrix_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} lm_state_t;

  function automatic int sel_width(input int num_inputs);
    return $clog2(num_inputs + 2);
  endfunction

  function automatic int osel_width(input int num_outputs);
    return (num_outputs > 1) ? $clog2(num_outputs) : 1;
  endfunction

  // Constant sources sit just above the physical input codes.
  function automatic int code_const0(input int num_inputs);
    return num_inputs;
  endfunction

  function automatic int code_const1(input int num_inputs);
    return num_inputs + 1;
  endfunction

endpackage

// File: rtl/line_matrix_loader_table.sv
// rtl/line_matrix_loader_table.sv - shadow/active routing tables with write check, snapshot and readback
module line_matrix_table
  import line_matrix_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_OUTPUTS = 10,
  parameter int SEL_W       = sel_width(NUM_INPUTS),
  parameter int OSEL_W      = osel_width(NUM_OUTPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [OSEL_W-1:0] wr_addr,
  input  logic [SEL_W-1:0]  wr_data,
  output logic              wr_err,
  input  logic [OSEL_W-1:0] rd_addr,
  output logic [SEL_W-1:0]  rd_data,
  input  logic              snap,
  input  logic [OSEL_W-1:0] act_addr,
  output logic [SEL_W-1:0]  act_code,
  output logic [SEL_W-1:0]  first_code
);

  localparam logic [SEL_W-1:0] CODE_ZERO = SEL_W'(code_const0(NUM_INPUTS));
  localparam int               MAX_CODE  = code_const1(NUM_INPUTS);

  logic [SEL_W-1:0] shadow      [NUM_OUTPUTS];
  logic [SEL_W-1:0] shadow_next [NUM_OUTPUTS];
  logic [SEL_W-1:0] active      [NUM_OUTPUTS];
  logic             wr_ok;

  assign wr_ok = wr_en && (32'(wr_addr) < NUM_OUTPUTS) && (32'(wr_data) <= MAX_CODE);

  // The snapshot copies the write-merged view so a same-cycle write is included.
  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      shadow_next[i] = shadow[i];
      if (wr_ok && (32'(wr_addr) == i))
        shadow_next[i] = wr_data;
    end
  end

  assign act_code   = (32'(act_addr) < NUM_OUTPUTS) ? active[act_addr] : CODE_ZERO;
  assign first_code = shadow_next[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        shadow[i] <= CODE_ZERO;
        active[i] <= CODE_ZERO;
      end
      wr_err  <= 1'b0;
      rd_data <= CODE_ZERO;
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        shadow[i] <= shadow_next[i];
        if (snap)
          active[i] <= shadow_next[i];
      end
      wr_err  <= wr_en && !wr_ok;
      rd_data <= (32'(rd_addr) < NUM_OUTPUTS) ? shadow[rd_addr] : CODE_ZERO;
    end
  end

endmodule

// File: rtl/line_matrix_loader.sv
// rtl/line_matrix_loader.sv - walks the routing table onto the line_matrix select interface
module line_matrix_loader
  import line_matrix_pkg::*;
#(
  parameter int NUM_INPUTS    = 8,
  parameter int NUM_OUTPUTS   = 10,
  parameter int SETTLE_CYCLES = 2,
  parameter int AUTO_LOAD     = 1,
  parameter int SEL_W         = sel_width(NUM_INPUTS),
  parameter int OSEL_W        = osel_width(NUM_OUTPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [OSEL_W-1:0] wr_addr,
  input  logic [SEL_W-1:0]  wr_data,
  output logic              wr_err,
  input  logic [OSEL_W-1:0] rd_addr,
  output logic [SEL_W-1:0]  rd_data,
  input  logic              commit,
  output logic              busy,
  output logic              done,
  output logic [OSEL_W-1:0] output_select,
  output logic [SEL_W-1:0]  input_select,
  output logic              sel_valid
);

  localparam int                CNT_W     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [OSEL_W-1:0] IDX_LAST  = OSEL_W'(NUM_OUTPUTS - 1);
  localparam logic [SEL_W-1:0]  CODE_ZERO = SEL_W'(code_const0(NUM_INPUTS));

  lm_state_t         state;
  logic [OSEL_W-1:0] index;
  logic [OSEL_W-1:0] next_index;
  logic [CNT_W-1:0]  settle_cnt;
  logic              pending;
  logic              auto_go;
  logic              start;
  logic [SEL_W-1:0]  act_code;
  logic [SEL_W-1:0]  first_code;

  assign next_index = index + 1'b1;
  assign start = ((state == IDLE) && (commit || auto_go)) ||
                 ((state == DONE) && (commit || pending));

  line_matrix_table #(
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_OUTPUTS(NUM_OUTPUTS),
    .SEL_W      (SEL_W),
    .OSEL_W     (OSEL_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .snap      (start),
    .act_addr  (next_index),
    .act_code  (act_code),
    .first_code(first_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      index         <= '0;
      settle_cnt    <= '0;
      pending       <= 1'b0;
      auto_go       <= (AUTO_LOAD != 0);
      busy          <= 1'b0;
      done          <= 1'b0;
      sel_valid     <= 1'b0;
      output_select <= '0;
      input_select  <= CODE_ZERO;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Pair 0 comes straight from the merged shadow, as the active copy lands this same edge.
        state         <= DRIVE;
        index         <= '0;
        settle_cnt    <= '0;
        pending       <= 1'b0;
        auto_go       <= 1'b0;
        busy          <= 1'b1;
        sel_valid     <= 1'b1;
        output_select <= '0;
        input_select  <= first_code;
      end else begin
        case (state)
          IDLE: ;
          DRIVE: begin
            if (commit)
              pending <= 1'b1;
            if (settle_cnt == CNT_LAST) begin
              settle_cnt <= '0;
              if (index == IDX_LAST) begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                sel_valid <= 1'b0;
              end else begin
                index         <= next_index;
                output_select <= next_index;
                input_select  <= act_code;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_matrix_loader.sv
// tb/tb_line_matrix_loader.sv - directed self-checking bench for line_matrix_loader
module tb_line_matrix_loader;

  logic       clk = 1'b0;
  logic       rst, wr_en, commit;
  logic [3:0] wr_addr, wr_data, rd_addr;
  logic       wr_err, busy, done, sel_valid;
  logic [3:0] rd_data, output_select, input_select;

  logic       rst2, wr_en2, commit2;
  logic [1:0] wr_addr2, rd_addr2, output_select2;
  logic [3:0] wr_data2, rd_data2, input_select2;
  logic       wr_err2, busy2, done2, sel_valid2;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int d0;

  logic [3:0] mat [10];
  logic [7:0] in_lines = 8'b10011001;
  logic [3:0] codes_a [10];
  logic [3:0] codes_b [10];
  logic [3:0] codes_c [10];
  logic [3:0] codes_r [10];

  always #5 clk = ~clk;

  line_matrix_loader dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .rd_addr(rd_addr), .rd_data(rd_data), .commit(commit),
    .busy(busy), .done(done), .output_select(output_select),
    .input_select(input_select), .sel_valid(sel_valid)
  );

  line_matrix_loader #(.NUM_OUTPUTS(3), .SETTLE_CYCLES(1), .AUTO_LOAD(0)) dut2 (
    .clk(clk), .rst(rst2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .wr_err(wr_err2), .rd_addr(rd_addr2), .rd_data(rd_data2), .commit(commit2),
    .busy(busy2), .done(done2), .output_select(output_select2),
    .input_select(input_select2), .sel_valid(sel_valid2)
  );

  // Stand-in for line_matrix: latch each driven pair and resolve the output lines.
  always @(posedge clk) begin
    if (sel_valid) mat[output_select] <= input_select;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [9:0] out_lines();
    logic [9:0] r;
    for (int o = 0; o < 10; o++)
      r[o] = (mat[o] < 4'd8) ? in_lines[mat[o][2:0]] : (mat[o] == 4'd9);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] a, input logic [3:0] d);
    wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d;
    tick();
    wr_en2 = 1'b0;
  endtask

  // Entered one cycle after the start edge; returns on the DONE cycle.
  task automatic walk_check(input string tag, input logic [3:0] codes [10], input bit inject);
    for (int c = 1; c <= 20; c++) begin
      int k;
      k = (c - 1) / 2;
      chk(tag, {busy, done, sel_valid, output_select, input_select},
          {1'b1, 1'b0, 1'b1, 4'(k), codes[k]});
      if (inject) begin
        wr_en = (c == 2); wr_addr = 4'd3; wr_data = 4'd7;
        commit = (c == 2) || (c == 4);
      end
      tick();
    end
    chk({tag, "_done"}, {busy, done, sel_valid, output_select, input_select},
        {3'b010, 4'd9, codes[9]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1; wr_en = 0; commit = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    rst2 = 1; wr_en2 = 0; commit2 = 0; wr_addr2 = 0; wr_data2 = 0; rd_addr2 = 0;
    for (int i = 0; i < 10; i++) begin
      codes_a[i] = 4'(i);
      codes_b[i] = 4'(i);
      codes_c[i] = 4'(i);
      codes_r[i] = 4'd8;
    end
    codes_b[3] = 4'd0;
    codes_c[3] = 4'd7;

    repeat (3) tick();
    chk("reset", {busy, done, sel_valid, output_select, input_select, wr_err, rd_data},
        {3'b000, 4'd0, 4'd8, 1'b0, 4'd8});
    chk("reset2", {busy2, done2, sel_valid2, output_select2, input_select2, wr_err2, rd_data2},
        {3'b000, 2'd0, 4'd8, 1'b0, 4'd8});

    rst = 0; rst2 = 0;
    tick();
    walk_check("auto_walk", codes_r, 1'b0);
    chk("auto_no_walk2", busy2, 1'b0);
    tick();
    chk("idle_after", {busy, done, sel_valid}, 3'b000);

    for (int k = 0; k < 9; k++) wr(4'(k), 4'(k));
    wr_en = 1; wr_addr = 4'd9; wr_data = 4'd9; commit = 1;
    tick();
    wr_en = 0; commit = 0;
    chk("wr_max_code_ok", wr_err, 1'b0);
    walk_check("walk_id", codes_a, 1'b0);
    chk("matrix_lines", out_lines(), 10'b1010011001);
    tick();

    rd_addr = 4'd4; tick();
    chk("rd_4", rd_data, 4'd4);
    wr(4'd10, 4'd5);
    chk("wr_err_addr", wr_err, 1'b1);
    tick();
    chk("wr_err_clear", wr_err, 1'b0);
    wr(4'd2, 4'd10);
    chk("wr_err_data", wr_err, 1'b1);
    rd_addr = 4'd2; tick();
    chk("rd_2_kept", {wr_err, rd_data}, {1'b0, 4'd2});
    rd_addr = 4'd10; tick();
    chk("rd_oob", rd_data, 4'd8);

    wr(4'd3, 4'd0);
    d0 = done_cnt;
    commit = 1; tick(); commit = 0;
    walk_check("walk_snap", codes_b, 1'b1);
    tick();
    walk_check("walk_rewalk", codes_c, 1'b0);
    tick();
    chk("hold_after", {busy, sel_valid, output_select, input_select}, {2'b00, 4'd9, 4'd9});
    repeat (3) tick();
    chk("single_rewalk", busy, 1'b0);
    chk("done_count", done_cnt - d0, 2);

    commit = 1; tick(); commit = 0;
    repeat (10) tick();
    chk("mid_walk_idx5", {busy, output_select}, {1'b1, 4'd5});
    rst = 1; tick();
    chk("mid_rst", {busy, done, sel_valid, output_select, input_select, wr_err, rd_data},
        {3'b000, 4'd0, 4'd8, 1'b0, 4'd8});
    rst = 0;
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a); tick();
      chk("rst_shadow", rd_data, 4'd8);
    end
    chk("auto_after_rst", busy, 1'b1);
    for (int i = 0; i < 40 && !done; i++) tick();
    chk("auto_rst_done", done, 1'b1);

    wr2(2'd0, 4'd9); wr2(2'd1, 4'd0); wr2(2'd2, 4'd5);
    chk("wr2_ok", wr_err2, 1'b0);
    wr2(2'd3, 4'd1);
    chk("wr2_err_addr", wr_err2, 1'b1);
    commit2 = 1; tick(); commit2 = 0;
    chk("s1_pair0", {busy2, done2, sel_valid2, output_select2, input_select2}, {3'b101, 2'd0, 4'd9});
    tick();
    chk("s1_pair1", {busy2, done2, sel_valid2, output_select2, input_select2}, {3'b101, 2'd1, 4'd0});
    tick();
    chk("s1_pair2", {busy2, done2, sel_valid2, output_select2, input_select2}, {3'b101, 2'd2, 4'd5});
    tick();
    chk("s1_done", {busy2, done2, sel_valid2, output_select2, input_select2}, {3'b010, 2'd2, 4'd5});
    tick();
    chk("s1_done_pulse", done2, 1'b0);

    commit2 = 1; tick(); commit2 = 0;
    tick();
    chk("s1_mid", output_select2, 2'd1);
    rst2 = 1; tick();
    chk("s1_rst", {busy2, done2, sel_valid2, output_select2, input_select2, wr_err2, rd_data2},
        {3'b000, 2'd0, 4'd8, 1'b0, 4'd8});
    rst2 = 0;
    repeat (4) tick();
    chk("s1_no_auto", {busy2, sel_valid2}, 2'b00);
    rd_addr2 = 2'd1; tick();
    chk("s1_rst_shadow", rd_data2, 4'd8);
    commit2 = 1; tick(); commit2 = 0;
    chk("s1_recommit", {busy2, done2, sel_valid2, output_select2, input_select2}, {3'b101, 2'd0, 4'd8});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
